// File: rtl/alu_arb.sv
// Two-port sequencer/arbiter sharing one external combinational 8-bit ALU.
// Optional per-port result counters when ALU_ARB_OPCNT_EN is defined.
module alu_arb #(
    parameter bit PRIO_FIXED = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        r0_valid,
    output logic        r0_ready,
    input  logic [7:0]  r0_a,
    input  logic [7:0]  r0_b,
    input  logic [2:0]  r0_s,
    output logic        r0_rvalid,
    input  logic        r0_rready,
    output logic [7:0]  r0_out,
    output logic [3:0]  r0_flags,
    input  logic        r1_valid,
    output logic        r1_ready,
    input  logic [7:0]  r1_a,
    input  logic [7:0]  r1_b,
    input  logic [2:0]  r1_s,
    output logic        r1_rvalid,
    input  logic        r1_rready,
    output logic [7:0]  r1_out,
    output logic [3:0]  r1_flags,
`ifdef ALU_ARB_OPCNT_EN
    input  logic        cnt_clr,
    output logic [15:0] r0_opcnt,
    output logic [15:0] r1_opcnt,
`endif
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [2:0]  alu_s,
    input  logic [7:0]  alu_out,
    input  logic        alu_z,
    input  logic        alu_n,
    input  logic        alu_c,
    input  logic        alu_v
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_owner;
    logic   r_last;
    logic   w_gnt1;
    logic   w_req;
    logic   w_rsp_done;

    assign w_req = r0_valid | r1_valid;

    // Tie-break: round-robin favours the port that did not finish last.
    always_comb begin
        if (r0_valid && r1_valid) begin
            w_gnt1 = PRIO_FIXED ? 1'b0 : ~r_last;
        end else begin
            w_gnt1 = r1_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        r0_ready    = 1'b0;
        r1_ready    = 1'b0;
        w_rsp_done  = 1'b0;
        case (r_state)
            IDLE: begin
                if (rst_n && w_req) begin
                    r0_ready    = ~w_gnt1;
                    r1_ready    = w_gnt1;
                    w_state_nxt = EXEC;
                end
            end
            EXEC: w_state_nxt = RESP;
            RESP: begin
                w_rsp_done = r_owner ? r1_rready : r0_rready;
                if (w_rsp_done) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a     <= 8'h00;
            alu_b     <= 8'h00;
            alu_s     <= 3'd0;
            r_owner   <= 1'b0;
            r_last    <= 1'b1;
            r0_rvalid <= 1'b0;
            r1_rvalid <= 1'b0;
            r0_out    <= 8'h00;
            r1_out    <= 8'h00;
            r0_flags  <= 4'h0;
            r1_flags  <= 4'h0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        alu_a   <= w_gnt1 ? r1_a : r0_a;
                        alu_b   <= w_gnt1 ? r1_b : r0_b;
                        alu_s   <= w_gnt1 ? r1_s : r0_s;
                        r_owner <= w_gnt1;
                    end
                end
                EXEC: begin
                    if (r_owner) begin
                        r1_out    <= alu_out;
                        r1_flags  <= {alu_z, alu_n, alu_c, alu_v};
                        r1_rvalid <= 1'b1;
                    end else begin
                        r0_out    <= alu_out;
                        r0_flags  <= {alu_z, alu_n, alu_c, alu_v};
                        r0_rvalid <= 1'b1;
                    end
                end
                RESP: begin
                    if (w_rsp_done) begin
                        r0_rvalid <= 1'b0;
                        r1_rvalid <= 1'b0;
                        r_last    <= r_owner;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_ARB_OPCNT_EN
    logic w_inc0;
    logic w_inc1;

    assign w_inc0 = r0_rvalid & r0_rready;
    assign w_inc1 = r1_rvalid & r1_rready;

    // Clear wins over increment; counters stick at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r0_opcnt <= 16'h0000;
            r1_opcnt <= 16'h0000;
        end else if (cnt_clr) begin
            r0_opcnt <= 16'h0000;
            r1_opcnt <= 16'h0000;
        end else begin
            if (w_inc0 && (r0_opcnt != 16'hFFFF)) begin
                r0_opcnt <= r0_opcnt + 16'd1;
            end
            if (w_inc1 && (r1_opcnt != 16'hFFFF)) begin
                r1_opcnt <= r1_opcnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_arb.sv
// Self-checking bench for alu_arb: directed scenarios plus randomized ops
// against a behavioural model; a second instance covers fixed priority.
module tb_alu_arb;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       r0_valid = 1'b0, r1_valid = 1'b0;
    logic       r0_rready = 1'b0, r1_rready = 1'b0;
    logic [7:0] r0_a = 8'h00, r0_b = 8'h00, r1_a = 8'h00, r1_b = 8'h00;
    logic [2:0] r0_s = 3'd0, r1_s = 3'd0;

    logic       r0_ready, r1_ready, r0_rvalid, r1_rvalid;
    logic [7:0] r0_out, r1_out;
    logic [3:0] r0_flags, r1_flags;
    logic [7:0] alu_a, alu_b, alu_out;
    logic [2:0] alu_s;
    logic       alu_z, alu_n, alu_c, alu_v;

    logic       fx_r0_ready, fx_r1_ready, fx_r0_rvalid, fx_r1_rvalid;
    logic [7:0] fx_r0_out, fx_r1_out;
    logic [3:0] fx_r0_flags, fx_r1_flags;
    logic [7:0] fx_alu_a, fx_alu_b, fx_alu_out;
    logic [2:0] fx_alu_s;
    logic       fx_alu_z, fx_alu_n, fx_alu_c, fx_alu_v;

`ifdef ALU_ARB_OPCNT_EN
    logic        cnt_clr = 1'b0;
    logic [15:0] r0_opcnt, r1_opcnt, fx_r0_opcnt, fx_r1_opcnt;
`endif

    int         errors = 0;
    int         checks = 0;
    logic       m_last;
    logic [7:0] m_out [2];
    logic [3:0] m_flags [2];

    // Reference ALU: returns {out, z, n, c, v}
    function automatic logic [11:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                            input logic [2:0] s);
        int         sa, sb, r;
        logic [7:0] o;
        logic       v;
        sa = int'($signed(a));
        sb = int'($signed(b));
        v  = 1'b0;
        o  = 8'h00;
        case (s)
            3'd0: begin r = sa + sb; o = a + b; v = (r > 127) || (r < -128); end
            3'd1: begin r = sa - sb; o = a - b; v = (r > 127) || (r < -128); end
            3'd2: o = a & b;
            3'd3: o = a | b;
            3'd4: o = a ^ b;
            3'd5: o = ~a;
            3'd6: o = {a[6:0], 1'b0};
            default: o = {1'b0, a[7:1]};
        endcase
        return {o, (o == 8'h00), o[7], 1'b0, v};
    endfunction

    assign {alu_out, alu_z, alu_n, alu_c, alu_v} = alu_ref(alu_a, alu_b, alu_s);
    assign {fx_alu_out, fx_alu_z, fx_alu_n, fx_alu_c, fx_alu_v} = alu_ref(fx_alu_a, fx_alu_b, fx_alu_s);

    always #5 clk = ~clk;

    alu_arb #(.PRIO_FIXED(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_s(r0_s),
        .r0_rvalid(r0_rvalid), .r0_rready(r0_rready), .r0_out(r0_out), .r0_flags(r0_flags),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_s(r1_s),
        .r1_rvalid(r1_rvalid), .r1_rready(r1_rready), .r1_out(r1_out), .r1_flags(r1_flags),
`ifdef ALU_ARB_OPCNT_EN
        .cnt_clr(cnt_clr), .r0_opcnt(r0_opcnt), .r1_opcnt(r1_opcnt),
`endif
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_out(alu_out),
        .alu_z(alu_z), .alu_n(alu_n), .alu_c(alu_c), .alu_v(alu_v)
    );

    alu_arb #(.PRIO_FIXED(1'b1)) dut_fx (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid), .r0_ready(fx_r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_s(r0_s),
        .r0_rvalid(fx_r0_rvalid), .r0_rready(r0_rready), .r0_out(fx_r0_out), .r0_flags(fx_r0_flags),
        .r1_valid(r1_valid), .r1_ready(fx_r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_s(r1_s),
        .r1_rvalid(fx_r1_rvalid), .r1_rready(r1_rready), .r1_out(fx_r1_out), .r1_flags(fx_r1_flags),
`ifdef ALU_ARB_OPCNT_EN
        .cnt_clr(cnt_clr), .r0_opcnt(fx_r0_opcnt), .r1_opcnt(fx_r1_opcnt),
`endif
        .alu_a(fx_alu_a), .alu_b(fx_alu_b), .alu_s(fx_alu_s), .alu_out(fx_alu_out),
        .alu_z(fx_alu_z), .alu_n(fx_alu_n), .alu_c(fx_alu_c), .alu_v(fx_alu_v)
    );

    task automatic test_reset();
        rst_n = 1'b0;
        r0_valid = 1'b1;
        r1_valid = 1'b1;
        @(negedge clk);
        checks++;
        if ({r0_ready, r1_ready, r0_rvalid, r1_rvalid} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_hs: got %b expected 0000", {r0_ready, r1_ready, r0_rvalid, r1_rvalid});
        end
        checks++;
        if ({r0_out, r0_flags, r1_out, r1_flags} !== 24'h0) begin
            errors++;
            $display("FAIL reset_res: got %h expected 000000", {r0_out, r0_flags, r1_out, r1_flags});
        end
        checks++;
        if ({alu_a, alu_b, alu_s} !== 19'h0) begin
            errors++;
            $display("FAIL reset_alu: got %h expected 0", {alu_a, alu_b, alu_s});
        end
        @(posedge clk); #1;
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        rst_n = 1'b1;
        m_last = 1'b1;
        m_out[0] = 8'h00; m_out[1] = 8'h00;
        m_flags[0] = 4'h0; m_flags[1] = 4'h0;
        @(negedge clk);
    endtask

    task automatic test_add_r0();
        @(posedge clk); #1;
        r0_valid = 1'b1; r0_a = 8'h7F; r0_b = 8'h01; r0_s = 3'd0;
        r0_rready = 1'b1; r1_rready = 1'b1;
        @(negedge clk);
        checks++;
        if ({r0_ready, r1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL add_ready: got %b expected 10", {r0_ready, r1_ready});
        end
        @(posedge clk); #1;
        r0_valid = 1'b0; r0_a = 8'hFF; r0_b = 8'hFF;
        @(negedge clk);
        checks++;
        if ({r0_rvalid, alu_a, alu_b} !== {1'b0, 8'h7F, 8'h01}) begin
            errors++;
            $display("FAIL add_exec: got %h expected 07f01", {r0_rvalid, alu_a, alu_b});
        end
        @(negedge clk);
        checks++;
        if ({r0_rvalid, r1_rvalid, r0_out, r0_flags} !== {2'b10, 8'h80, 4'b0101}) begin
            errors++;
            $display("FAIL add_resp: got rv=%b%b out=%h fl=%b expected rv=10 out=80 fl=0101",
                     r0_rvalid, r1_rvalid, r0_out, r0_flags);
        end
        @(negedge clk);
        checks++;
        if (r0_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL add_done: got rvalid=%b expected 0", r0_rvalid);
        end
        r1_rready = 1'b0;
        m_last = 1'b0; m_out[0] = 8'h80; m_flags[0] = 4'b0101;
    endtask

    task automatic test_sub_r1();
        @(posedge clk); #1;
        r1_valid = 1'b1; r1_a = 8'h05; r1_b = 8'h05; r1_s = 3'd1; r1_rready = 1'b1;
        @(negedge clk);
        checks++;
        if ({r0_ready, r1_ready} !== 2'b01) begin
            errors++;
            $display("FAIL sub_ready: got %b expected 01", {r0_ready, r1_ready});
        end
        @(posedge clk); #1;
        r1_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({r1_rvalid, r0_rvalid, r1_out, r1_flags} !== {2'b10, 8'h00, 4'b1000}) begin
            errors++;
            $display("FAIL sub_resp: got rv=%b%b out=%h fl=%b expected rv=10 out=00 fl=1000",
                     r1_rvalid, r0_rvalid, r1_out, r1_flags);
        end
        checks++;
        if ({r0_out, r0_flags} !== {8'h80, 4'b0101}) begin
            errors++;
            $display("FAIL sub_r0_keep: got %h/%b expected 80/0101", r0_out, r0_flags);
        end
        @(negedge clk);
        m_last = 1'b1; m_out[1] = 8'h00; m_flags[1] = 4'b1000;
    endtask

    task automatic test_ties();
        logic [11:0] exp [2];
        int          n_gnt, fx_n0, fx_n1;
        logic        g;
        n_gnt = 0; fx_n0 = 0; fx_n1 = 0;
        @(posedge clk); #1;
        r0_a = 8'($urandom); r0_b = 8'($urandom); r0_s = 3'($urandom);
        r1_a = 8'($urandom); r1_b = 8'($urandom); r1_s = 3'($urandom);
        exp[0] = alu_ref(r0_a, r0_b, r0_s);
        exp[1] = alu_ref(r1_a, r1_b, r1_s);
        r0_valid = 1'b1; r1_valid = 1'b1; r0_rready = 1'b1; r1_rready = 1'b1;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if (fx_r0_ready) fx_n0++;
            if (fx_r1_ready) fx_n1++;
            if (r0_ready || r1_ready) begin
                g = r1_ready;
                n_gnt++;
                checks++;
                if ({r0_ready, r1_ready} !== {m_last, ~m_last}) begin
                    errors++;
                    $display("FAIL rr_grant: got %b expected %b", {r0_ready, r1_ready}, {m_last, ~m_last});
                end
                m_last = g;
            end
            if (r0_rvalid || r1_rvalid) begin
                g = r1_rvalid;
                checks++;
                if ({(g ? r1_out : r0_out), (g ? r1_flags : r0_flags)} !== exp[g]) begin
                    errors++;
                    $display("FAIL rr_result: port %0d got %h expected %h", g,
                             {(g ? r1_out : r0_out), (g ? r1_flags : r0_flags)}, exp[g]);
                end
                m_out[g] = exp[g][11:4];
                m_flags[g] = exp[g][3:0];
            end
        end
        checks++;
        if (n_gnt !== 6) begin
            errors++;
            $display("FAIL rr_count: got %0d expected 6", n_gnt);
        end
        checks++;
        if ({fx_n0, fx_n1} !== {32'd6, 32'd0}) begin
            errors++;
            $display("FAIL fixed_prio: got p0=%0d p1=%0d expected p0=6 p1=0", fx_n0, fx_n1);
        end
        @(posedge clk); #1;
        r0_valid = 1'b0; r1_valid = 1'b0;
        @(negedge clk);
        // An op granted on the last sampled edge completes here.
        if (r0_rvalid || r1_rvalid) begin
            g = r1_rvalid;
            m_out[g] = exp[g][11:4];
            m_flags[g] = exp[g][3:0];
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_stall();
        logic [11:0] e1;
        @(posedge clk); #1;
        r0_valid = 1'b1; r0_a = 8'hC3; r0_b = 8'h00; r0_s = 3'd6; r0_rready = 1'b0; r1_rready = 1'b1;
        @(negedge clk);
        checks++;
        if (r0_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_ready: got %b expected 1", r0_ready);
        end
        @(posedge clk); #1;
        r0_valid = 1'b0;
        r1_valid = 1'b1; r1_a = 8'h3C; r1_b = 8'h0F; r1_s = 3'd2;
        e1 = alu_ref(8'h3C, 8'h0F, 3'd2);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({r0_rvalid, r0_out, r0_flags, r1_ready, r1_rvalid} !== {1'b1, 8'h86, 4'b0100, 2'b00}) begin
                errors++;
                $display("FAIL stall_hold%0d: got rv=%b out=%h fl=%b r1rdy=%b r1rv=%b expected 1/86/0100/0/0",
                         i, r0_rvalid, r0_out, r0_flags, r1_ready, r1_rvalid);
            end
        end
        @(posedge clk); #1;
        r0_rready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({r0_rvalid, r1_ready} !== 2'b01) begin
            errors++;
            $display("FAIL stall_release: got rv=%b r1rdy=%b expected 0/1", r0_rvalid, r1_ready);
        end
        m_last = 1'b0; m_out[0] = 8'h86; m_flags[0] = 4'b0100;
        @(posedge clk); #1;
        r1_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({r1_rvalid, r1_out, r1_flags} !== {1'b1, e1}) begin
            errors++;
            $display("FAIL stall_r1: got %h expected %h", {r1_rvalid, r1_out, r1_flags}, {1'b1, e1});
        end
        @(negedge clk);
        m_last = 1'b1; m_out[1] = e1[11:4]; m_flags[1] = e1[3:0];
    endtask

    task automatic test_reset_mid();
        logic [11:0] e0;
        @(posedge clk); #1;
        r1_valid = 1'b1; r1_a = 8'h0F; r1_s = 3'd5; r1_rready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        r1_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        r0_valid = 1'b1; r1_valid = 1'b1;
        r0_a = 8'h12; r0_b = 8'h34; r0_s = 3'd4; r0_rready = 1'b1;
        e0 = alu_ref(8'h12, 8'h34, 3'd4);
        #1;
        checks++;
        if ({r0_ready, r1_ready, r0_rvalid, r1_rvalid, r0_out, r0_flags, r1_out, r1_flags, alu_a} !== 36'h0) begin
            errors++;
            $display("FAIL midrst_clear: got %h expected 0",
                     {r0_ready, r1_ready, r0_rvalid, r1_rvalid, r0_out, r0_flags, r1_out, r1_flags, alu_a});
        end
        @(posedge clk); #1;
        checks++;
        if ({r1_rvalid, r1_out} !== 9'h0) begin
            errors++;
            $display("FAIL midrst_discard: got %h expected 000", {r1_rvalid, r1_out});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({r0_ready, r1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL midrst_tie: got %b expected 10", {r0_ready, r1_ready});
        end
        @(posedge clk); #1;
        r0_valid = 1'b0; r1_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({r0_rvalid, r0_out, r0_flags} !== {1'b1, e0}) begin
            errors++;
            $display("FAIL midrst_op: got %h expected %h", {r0_rvalid, r0_out, r0_flags}, {1'b1, e0});
        end
        @(negedge clk);
        m_last = 1'b0; m_out[0] = e0[11:4]; m_flags[0] = e0[3:0]; m_out[1] = 8'h00; m_flags[1] = 4'h0;
    endtask

    task automatic test_random();
        int          mode, dly;
        logic        p, got;
        logic [11:0] e;
        for (int n = 0; n < 40; n++) begin
            mode = $urandom_range(0, 2);
            dly  = $urandom_range(0, 3);
            @(posedge clk); #1;
            r0_a = 8'($urandom); r0_b = 8'($urandom); r0_s = 3'($urandom);
            r1_a = 8'($urandom); r1_b = 8'($urandom); r1_s = 3'($urandom);
            r0_valid = (mode != 1); r1_valid = (mode != 0);
            r0_rready = 1'b0; r1_rready = 1'b0;
            p = (mode == 2) ? ~m_last : (mode == 1);
            e = p ? alu_ref(r1_a, r1_b, r1_s) : alu_ref(r0_a, r0_b, r0_s);
            got = 1'b0;
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                if (r0_ready || r1_ready) begin got = 1'b1; break; end
            end
            checks++;
            if (!got || ({r0_ready, r1_ready} !== {~p, p})) begin
                errors++;
                $display("FAIL rnd_grant%0d: got %b expected %b", n, {r0_ready, r1_ready}, {~p, p});
            end
            @(posedge clk); #1;
            r0_valid = 1'b0; r1_valid = 1'b0;
            r0_a = 8'($urandom); r1_a = 8'($urandom); r0_s = 3'($urandom); r1_s = 3'($urandom);
            got = 1'b0;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                if (p ? r1_rvalid : r0_rvalid) begin got = 1'b1; break; end
            end
            checks++;
            if (!got || ({(p ? r1_out : r0_out), (p ? r1_flags : r0_flags)} !== e)) begin
                errors++;
                $display("FAIL rnd_result%0d: port %0d got %h expected %h", n, p,
                         {(p ? r1_out : r0_out), (p ? r1_flags : r0_flags)}, e);
            end
            checks++;
            if ({(p ? r0_rvalid : r1_rvalid), (p ? r0_out : r1_out), (p ? r0_flags : r1_flags)}
                    !== {1'b0, m_out[~p], m_flags[~p]}) begin
                errors++;
                $display("FAIL rnd_other%0d: got %h expected %h", n,
                         {(p ? r0_rvalid : r1_rvalid), (p ? r0_out : r1_out), (p ? r0_flags : r1_flags)},
                         {1'b0, m_out[~p], m_flags[~p]});
            end
            for (int k = 0; k < dly; k++) begin
                @(posedge clk); #1;
                if (p) r0_rready = 1'b1; else r1_rready = 1'b1;
                @(negedge clk);
                checks++;
                if ({(p ? r1_rvalid : r0_rvalid), (p ? r1_out : r0_out), (p ? r1_flags : r0_flags)} !== {1'b1, e}) begin
                    errors++;
                    $display("FAIL rnd_hold%0d: got %h expected %h", n,
                             {(p ? r1_rvalid : r0_rvalid), (p ? r1_out : r0_out), (p ? r1_flags : r0_flags)}, {1'b1, e});
                end
            end
            @(posedge clk); #1;
            r0_rready = ~p; r1_rready = p;
            @(negedge clk);
            @(posedge clk); #1;
            r0_rready = 1'b0; r1_rready = 1'b0;
            @(negedge clk);
            checks++;
            if ({r0_rvalid, r1_rvalid} !== 2'b00) begin
                errors++;
                $display("FAIL rnd_done%0d: got %b expected 00", n, {r0_rvalid, r1_rvalid});
            end
            m_last = p; m_out[p] = e[11:4]; m_flags[p] = e[3:0];
        end
    endtask

`ifdef ALU_ARB_OPCNT_EN
    task automatic run_op0();
        logic got;
        @(posedge clk); #1;
        r0_valid = 1'b1; r0_rready = 1'b1; r0_a = 8'($urandom); r0_b = 8'($urandom); r0_s = 3'($urandom);
        got = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (r0_ready) begin got = 1'b1; break; end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL cnt_op_timeout: got no ready expected ready");
        end
        @(posedge clk); #1;
        r0_valid = 1'b0;
        repeat (3) @(negedge clk);
        r0_rready = 1'b0;
        m_last = 1'b0;
    endtask

    task automatic test_opcnt();
        @(posedge clk); #1; cnt_clr = 1'b1;
        @(posedge clk); #1; cnt_clr = 1'b0;
        @(negedge clk);
        checks++;
        if ({r0_opcnt, r1_opcnt} !== 32'h0) begin
            errors++;
            $display("FAIL cnt_clr0: got %h expected 0", {r0_opcnt, r1_opcnt});
        end
        repeat (3) run_op0();
        checks++;
        if (r0_opcnt !== 16'd3) begin
            errors++;
            $display("FAIL cnt_three: got %0d expected 3", r0_opcnt);
        end
        @(posedge clk); #1; cnt_clr = 1'b1;
        @(posedge clk); #1; cnt_clr = 1'b0;
        @(negedge clk);
        checks++;
        if (r0_opcnt !== 16'd0) begin
            errors++;
            $display("FAIL cnt_clr1: got %0d expected 0", r0_opcnt);
        end
        run_op0();
        checks++;
        if ({r0_opcnt, r1_opcnt} !== {16'd1, 16'd0}) begin
            errors++;
            $display("FAIL cnt_one: got %h expected 00010000", {r0_opcnt, r1_opcnt});
        end
    endtask
`endif

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add_r0();
        test_sub_r1();
        test_ties();
        test_stall();
        test_reset_mid();
        test_random();
`ifdef ALU_ARB_OPCNT_EN
        test_opcnt();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
